// File: rtl/ascii_to_int32.sv
// Streams ASCII chars into signed 32-bit numbers; num_valid rises the cycle after the delimiter, char_ready drops while a number awaits num_ready.
// Optional ASCII_PARSE_PLUS_EN accepts a leading '+' as an explicit positive sign.
module ascii_to_int32 #(
  parameter int MAX_DIGITS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [31:0] num_out,
  output logic        num_last,
  output logic        num_valid,
  input  logic        num_ready,
  output logic        error,
  output logic        busy
);

  localparam int CW = $clog2(MAX_DIGITS + 2);

  typedef enum logic [2:0] {IDLE, SIGN, DIGITS, EMIT, SKIP} state_t;

  state_t        r_state, w_state_nxt;
  logic [33:0]   r_acc, w_acc_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_neg, w_neg_nxt;
  logic          r_last, w_last_nxt;
  logic          r_err, w_err_nxt;

  logic          w_accept, w_is_delim, w_is_digit, w_is_minus, w_is_plus;
  logic [3:0]    w_digit;
  logic [33:0]   w_base_acc;
  logic [CW-1:0] w_base_cnt, w_cnt_inc;
  logic [37:0]   w_prod, w_limit;
  logic          w_ovf;
  logic [31:0]   w_mag;

  assign w_accept   = char_valid && char_ready;
  assign w_is_delim = (char_in == 8'h20) || (char_in == 8'h2C) || (char_in == 8'h09) ||
                      (char_in == 8'h0D) || (char_in == 8'h0A);
  assign w_is_digit = (char_in >= 8'h30) && (char_in <= 8'h39);
  assign w_is_minus = (char_in == 8'h2D);
`ifdef ASCII_PARSE_PLUS_EN
  assign w_is_plus  = (char_in == 8'h2B);
`else
  assign w_is_plus  = 1'b0;
`endif
  assign w_digit    = char_in[3:0];

  // A digit outside DIGITS starts a fresh number, so accumulate from zero.
  assign w_base_acc = (r_state == DIGITS) ? r_acc : 34'd0;
  assign w_base_cnt = (r_state == DIGITS) ? r_cnt : '0;
  assign w_cnt_inc  = w_base_cnt + CW'(1);
  assign w_prod     = ({4'b0, w_base_acc} * 38'd10) + {34'b0, w_digit};
  assign w_limit    = r_neg ? 38'd2147483648 : 38'd2147483647;
  assign w_ovf      = (w_prod > w_limit) || (w_cnt_inc > CW'(MAX_DIGITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_neg   <= w_neg_nxt;
      r_last  <= w_last_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_neg_nxt   = r_neg;
    w_last_nxt  = r_last;
    w_err_nxt   = 1'b0;

    case (r_state)
      IDLE, SIGN, DIGITS: begin
        if (w_accept) begin
          if (w_is_digit) begin
            if (w_ovf) begin
              w_state_nxt = SKIP;
              w_err_nxt   = 1'b1;
            end else begin
              w_state_nxt = DIGITS;
              w_acc_nxt   = w_prod[33:0];
              w_cnt_nxt   = w_cnt_inc;
            end
          end else if (w_is_delim) begin
            if (r_state == DIGITS) begin
              w_state_nxt = EMIT;
              w_last_nxt  = (char_in == 8'h0A);
            end else if (r_state == SIGN) begin
              w_state_nxt = IDLE;
              w_neg_nxt   = 1'b0;
              w_err_nxt   = 1'b1;
            end
          end else if ((r_state == IDLE) && (w_is_minus || w_is_plus)) begin
            w_state_nxt = SIGN;
            w_neg_nxt   = w_is_minus;
          end else begin
            w_state_nxt = SKIP;
            w_err_nxt   = 1'b1;
          end
        end
      end
      EMIT: begin
        if (num_ready) begin
          w_state_nxt = IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_neg_nxt   = 1'b0;
          w_last_nxt  = 1'b0;
        end
      end
      SKIP: begin
        if (w_accept && w_is_delim) begin
          w_state_nxt = IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_neg_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // acc never exceeds 2^31, so the 32-bit negate yields 32'h80000000 for the minimum.
  assign w_mag      = r_acc[31:0];
  assign num_valid  = (r_state == EMIT);
  assign num_out    = num_valid ? (r_neg ? (32'd0 - w_mag) : w_mag) : 32'd0;
  assign num_last   = num_valid && r_last;
  assign char_ready = (r_state != EMIT);
  assign error      = r_err;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_ascii_to_int32.sv
// Directed bench for ascii_to_int32: character strings in, emitted numbers and error pulses checked.
module tb_ascii_to_int32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [31:0] num_out;
  logic        num_last;
  logic        num_valid;
  logic        num_ready = 1'b1;
  logic        error;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_errp = 0;
  int n_both = 0;
  int last_err_cyc = -1;
  int a_cyc = 0;
  logic [31:0] q_num[$];
  logic        q_last[$];

  ascii_to_int32 dut (
    .clk(clk), .rst_n(rst_n),
    .char_in(char_in), .char_valid(char_valid), .char_ready(char_ready),
    .num_out(num_out), .num_last(num_last), .num_valid(num_valid), .num_ready(num_ready),
    .error(error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (num_valid && num_ready) begin
        q_num.push_back(num_out);
        q_last.push_back(num_last);
      end
      if (error) begin
        n_errp = n_errp + 1;
        last_err_cyc = cyc;
      end
      if (error && num_valid) n_both = n_both + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pop_num();
    if (q_num.size() > 0) return q_num.pop_front();
    return 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] pop_last();
    if (q_last.size() > 0) return {31'd0, q_last.pop_front()};
    return 32'hxxxxxxxx;
  endfunction

  task automatic put(input logic [7:0] c);
    int t;
    t = 0;
    char_in = c;
    char_valid = 1'b1;
    @(negedge clk);
    while (!char_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("char_ready_timeout", (t >= 50) ? 32'd1 : 32'd0, 32'd0);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic puts(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    q_num.delete();
    q_last.delete();
    n_errp = 0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_char_ready", {31'd0, char_ready}, 32'd1);
    chk("rst_num_valid",  {31'd0, num_valid},  32'd0);
    chk("rst_num_out",    num_out,             32'd0);
    chk("rst_num_last",   {31'd0, num_last},   32'd0);
    chk("rst_error",      {31'd0, error},      32'd0);
    chk("rst_busy",       {31'd0, busy},       32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    settle();

    // Basic positive and negative, newline tag
    clear_obs();
    puts("123 -45\n");
    settle();
    chk("basic_count", q_num.size(), 32'd2);
    chk("basic_v0",    pop_num(),    32'd123);
    chk("basic_l0",    pop_last(),   32'd0);
    chk("basic_v1",    pop_num(),    32'hFFFFFFD3);
    chk("basic_l1",    pop_last(),   32'd1);
    chk("basic_err",   n_errp,       32'd0);

    // Range extremes
    clear_obs();
    puts("2147483647,-2147483648,");
    settle();
    chk("ext_count", q_num.size(), 32'd2);
    chk("ext_max",   pop_num(),    32'h7FFFFFFF);
    chk("ext_min",   pop_num(),    32'h80000000);
    chk("ext_err",   n_errp,       32'd0);

    clear_obs();
    puts("2147483648,");
    settle();
    chk("ovf_err",   n_errp,       32'd1);
    chk("ovf_count", q_num.size(), 32'd0);

    // Invalid char mid-token, error timing, skip to delimiter
    clear_obs();
    puts("12");
    put(8'h61);
    a_cyc = cyc;
    puts("4 7 ");
    settle();
    chk("inv_err",     n_errp,       32'd1);
    chk("inv_err_cyc", last_err_cyc, a_cyc);
    chk("inv_count",   q_num.size(), 32'd1);
    chk("inv_val",     pop_num(),    32'd7);

    // Lone sign and too many digits
    clear_obs();
    puts("- 00000000005 ");
    settle();
    chk("digits_err",   n_errp,       32'd2);
    chk("digits_count", q_num.size(), 32'd0);
    clear_obs();
    puts("0000000005 ");
    settle();
    chk("lead0_val", pop_num(), 32'd5);
    chk("lead0_err", n_errp,    32'd0);

    // Negative zero and repeated delimiters
    clear_obs();
    puts("-0 \r\n, ");
    settle();
    chk("negzero_count", q_num.size(), 32'd1);
    chk("negzero_val",   pop_num(),    32'd0);

    // Backpressure
    clear_obs();
    num_ready = 1'b0;
    puts("9\n");
    @(negedge clk);
    chk("bp_valid0", {31'd0, num_valid},  32'd1);
    chk("bp_ready0", {31'd0, char_ready}, 32'd0);
    chk("bp_busy",   {31'd0, busy},       32'd1);
    repeat (5) @(negedge clk);
    chk("bp_valid5", {31'd0, num_valid},  32'd1);
    chk("bp_out5",   num_out,             32'd9);
    chk("bp_last5",  {31'd0, num_last},   32'd1);
    chk("bp_ready5", {31'd0, char_ready}, 32'd0);
    @(posedge clk);
    #1 num_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_rel_valid", {31'd0, num_valid},  32'd0);
    chk("bp_rel_ready", {31'd0, char_ready}, 32'd1);
    chk("bp_rel_busy",  {31'd0, busy},       32'd0);
    settle();
    chk("bp_count", q_num.size(), 32'd1);

    // Reset mid-token discards it
    clear_obs();
    puts("56");
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    puts("7\n");
    settle();
    chk("mid_rst_count", q_num.size(), 32'd1);
    chk("mid_rst_val",   pop_num(),    32'd7);
    chk("mid_rst_last",  pop_last(),   32'd1);

    // Explicit plus sign
    clear_obs();
    puts("+8,");
    settle();
`ifdef ASCII_PARSE_PLUS_EN
    chk("plus_val", pop_num(), 32'd8);
    chk("plus_err", n_errp,    32'd0);
`else
    chk("plus_count", q_num.size(), 32'd0);
    chk("plus_err",   n_errp,       32'd1);
`endif

    chk("err_with_valid", n_both, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
